alu_exec_stage: RTL and testbench

- Registered execute stage that consumes the 3-bit `alucontrol` produced by the ALU control decoder.
- Applies the decoded operation to two operands and holds the result in an output register under a valid/ready handshake.
- Sits between the decode/register-read logic and the memory/writeback path of the Lab 2 datapath.
- Also reports zero, signed overflow, an illegal-code flag, and a retired-operation counter for debug.

---
 rtl/alu_exec_stage_pkg.sv | 26 ++
 rtl/alu_exec_stage_if.sv | 32 +++
 rtl/alu_exec_stage_core.sv | 52 +++++
 rtl/alu_exec_stage.sv | 91 +++++++++
 tb/tb_alu_exec_stage.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/alu_exec_stage_pkg.sv
// Shared ALU definitions: control codes, ALUOp encodings and execute-stage states.
package alu_pkg;

  // 3-bit operation codes produced by the ALU control decoder
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_e;

  // 2-bit ALUOp from the main decoder (consumed by the ALU control decoder)
  typedef enum logic [1:0] {
    ALUOP_MEM   = 2'b00,
    ALUOP_BEQ   = 2'b01,
    ALUOP_RTYPE = 2'b10
  } alu_op_e;

  // Execute-stage occupancy: the output register is either empty or holds a result
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_e;

endpackage

// File: rtl/alu_exec_stage_if.sv
// Request/response bundle for the ALU execute stage.
interface alu_exec_stage_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CNT_WIDTH = 16
);

  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           alucontrol;
  logic [WIDTH-1:0]     src_a;
  logic [WIDTH-1:0]     src_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     result;
  logic                 zero;
  logic                 overflow;
  logic                 illegal;
  logic [CNT_WIDTH-1:0] op_count;

  // Upstream/downstream environment driving the stage
  modport master (
    output in_valid, alucontrol, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero, overflow, illegal, op_count
  );

  // The execute stage itself
  modport slave (
    input  in_valid, alucontrol, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero, overflow, illegal, op_count
  );

endinterface

// File: rtl/alu_exec_stage_core.sv
// Combinational ALU: decoded operation, signed overflow and illegal-code flag.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       control,
  output logic [WIDTH-1:0] y,
  output logic             ovf,
  output logic             illegal
);

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_ovf_add;
  logic             w_ovf_sub;
  logic             w_lt;

  // Shared adder/subtractor results and their signed-overflow conditions
  always_comb begin
    w_sum     = a + b;
    w_diff    = a - b;
    w_ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1]  != a[WIDTH-1]);
    w_ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
    // sign of a-b corrected by overflow gives the true signed comparison
    w_lt      = w_diff[WIDTH-1] ^ w_ovf_sub;
  end

  // Operation select; undefined codes yield zero and raise illegal
  always_comb begin
    y       = '0;
    ovf     = 1'b0;
    illegal = 1'b0;
    case (control)
      ALU_ADD: begin
        y   = w_sum;
        ovf = w_ovf_add;
      end
      ALU_SUB: begin
        y   = w_diff;
        ovf = w_ovf_sub;
      end
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {{(WIDTH-1){1'b0}}, w_lt};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage: single-entry output register with valid/ready
// handshake, result flags and a wrapping count of consumed results.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_exec_stage_if.slave bus
);

  stage_state_e         r_state;
  stage_state_e         w_state_nxt;
  logic                 w_out_valid;
  logic                 w_in_ready;
  logic                 w_in_xfer;
  logic                 w_out_xfer;

  logic [WIDTH-1:0]     w_y;
  logic                 w_ovf;
  logic                 w_illegal;

  logic [WIDTH-1:0]     r_result;
  logic                 r_zero;
  logic                 r_overflow;
  logic                 r_illegal;
  logic [CNT_WIDTH-1:0] r_op_count;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a       (bus.src_a),
    .b       (bus.src_b),
    .control (bus.alucontrol),
    .y       (w_y),
    .ovf     (w_ovf),
    .illegal (w_illegal)
  );

  // Occupancy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Next state: an accepted input always leaves the stage full (covers the
  // consume-and-refill case); otherwise a consume empties it
  always_comb begin
    w_state_nxt = r_state;
    if (w_in_xfer)       w_state_nxt = ST_FULL;
    else if (w_out_xfer) w_state_nxt = ST_EMPTY;
  end

  // Handshake outputs; in_ready passes through a same-cycle consume
  always_comb begin
    w_out_valid = (r_state == ST_FULL);
    w_in_ready  = !w_out_valid || bus.out_ready;
    w_in_xfer   = bus.in_valid && w_in_ready;
    w_out_xfer  = w_out_valid && bus.out_ready;
  end

  // Result register loads only on an accepted input, so it holds under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_overflow <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (w_in_xfer) begin
      r_result   <= w_y;
      r_zero     <= (w_y == '0);
      r_overflow <= w_ovf;
      r_illegal  <= w_illegal;
    end
  end

  // Consumed-result counter, wraps naturally at 2^CNT_WIDTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_op_count <= '0;
    else if (w_out_xfer) r_op_count <= r_op_count + CNT_WIDTH'(1);
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;
  assign bus.overflow  = r_overflow;
  assign bus.illegal   = r_illegal;
  assign bus.op_count  = r_op_count;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed self-checking bench for alu_exec_stage (CNT_WIDTH=4 to reach counter wrap).
module tb_alu_exec_stage;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 4;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;
  logic [CW-1:0] exp_cnt;

  alu_exec_stage_if #(.WIDTH(W), .CNT_WIDTH(CW)) bus ();

  alu_exec_stage #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Accept one op with out_ready=1, check the registered result, then let it be consumed
  task automatic do_op(input string tag, input logic [2:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input logic ez,
                       input logic eo, input logic ei);
    chk({tag, "_pre_valid"}, 64'(bus.out_valid), 64'd0);
    bus.alucontrol = c;
    bus.src_a      = a;
    bus.src_b      = b;
    bus.in_valid   = 1'b1;
    bus.out_ready  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk({tag, "_valid"},    64'(bus.out_valid), 64'd1);
    chk({tag, "_result"},   64'(bus.result),    64'(er));
    chk({tag, "_zero"},     64'(bus.zero),      64'(ez));
    chk({tag, "_overflow"}, 64'(bus.overflow),  64'(eo));
    chk({tag, "_illegal"},  64'(bus.illegal),   64'(ei));
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 4'd1;
    chk({tag, "_consumed"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_op_count"}, 64'(bus.op_count),  64'(exp_cnt));
  endtask

  initial begin
    n_pass         = 0;
    n_total        = 0;
    exp_cnt        = '0;
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.alucontrol = 3'b000;
    bus.src_a      = '0;
    bus.src_b      = '0;

    // Power-on reset state
    #3;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_result",    64'(bus.result),    64'd0);
    chk("rst_zero",      64'(bus.zero),      64'd0);
    chk("rst_overflow",  64'(bus.overflow),  64'd0);
    chk("rst_illegal",   64'(bus.illegal),   64'd0);
    chk("rst_op_count",  64'(bus.op_count),  64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic operations
    do_op("add",      3'b010, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0, 1'b0);
    do_op("sub",      3'b110, 32'd7,          32'd7,          32'd0,          1'b1, 1'b0, 1'b0);
    do_op("and",      3'b000, 32'h0000_F0F0,  32'h0000_0FF0,  32'h0000_00F0,  1'b0, 1'b0, 1'b0);
    do_op("or",       3'b001, 32'h0000_F0F0,  32'h0000_0FF0,  32'h0000_FFF0,  1'b0, 1'b0, 1'b0);
    // Overflow and signed compare across overflow
    do_op("add_ovf",  3'b010, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b0, 1'b1, 1'b0);
    do_op("sub_ovf",  3'b110, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0, 1'b1, 1'b0);
    do_op("slt_neg",  3'b111, 32'h8000_0000,  32'd1,          32'd1,          1'b0, 1'b0, 1'b0);
    do_op("slt_pos",  3'b111, 32'h7FFF_FFFF,  32'hFFFF_FFFF,  32'd0,          1'b1, 1'b0, 1'b0);
    // Undefined codes
    do_op("ill_101",  3'b101, 32'd3,          32'd4,          32'd0,          1'b1, 1'b0, 1'b1);
    do_op("ill_011",  3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          1'b1, 1'b0, 1'b1);
    do_op("ill_100",  3'b100, 32'h7FFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0, 1'b1);

    // Backpressure: fill with 1+2, then hold out_ready low for 4 cycles
    bus.out_ready  = 1'b0;
    bus.alucontrol = 3'b010;
    bus.src_a      = 32'd1;
    bus.src_b      = 32'd2;
    bus.in_valid   = 1'b1;
    @(posedge clk); #1;
    chk("bp_fill_valid",  64'(bus.out_valid), 64'd1);
    chk("bp_fill_result", 64'(bus.result),    64'd3);
    for (int i = 0; i < 4; i++) begin
      bus.alucontrol = (i % 2 == 0) ? 3'b110 : 3'b101;
      bus.src_a      = 32'(100 + i);
      bus.src_b      = 32'(7 * i);
      #1;
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clk); #1;
      chk("bp_hold_result",  64'(bus.result),   64'd3);
      chk("bp_hold_illegal", 64'(bus.illegal),  64'd0);
      chk("bp_hold_count",   64'(bus.op_count), 64'(exp_cnt));
    end
    // Release: consume 3 and accept 10+20 in the same edge
    bus.alucontrol = 3'b010;
    bus.src_a      = 32'd10;
    bus.src_b      = 32'd20;
    bus.out_ready  = 1'b1;
    #1;
    chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    exp_cnt = exp_cnt + 4'd1;
    chk("bp_swap_valid",  64'(bus.out_valid), 64'd1);
    chk("bp_swap_result", 64'(bus.result),    64'd30);
    chk("bp_swap_count",  64'(bus.op_count),  64'(exp_cnt));
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 4'd1;
    chk("bp_drain_valid", 64'(bus.out_valid), 64'd0);
    chk("bp_drain_count", 64'(bus.op_count),  64'd13);

    // Asynchronous reset while holding a result
    bus.out_ready  = 1'b0;
    bus.alucontrol = 3'b010;
    bus.src_a      = 32'd1;
    bus.src_b      = 32'd1;
    bus.in_valid   = 1'b1;
    @(posedge clk); #1;
    chk("mid_full_valid", 64'(bus.out_valid), 64'd1);
    chk("mid_full_result", 64'(bus.result),   64'd2);
    #2;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    exp_cnt = '0;
    chk("mid_rst_valid",    64'(bus.out_valid), 64'd0);
    chk("mid_rst_result",   64'(bus.result),    64'd0);
    chk("mid_rst_op_count", 64'(bus.op_count),  64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready),  64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming 17 back-to-back adds; counter wraps through 16
    bus.out_ready  = 1'b1;
    bus.alucontrol = 3'b010;
    bus.in_valid   = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.src_a = 32'(i);
      bus.src_b = 32'd1;
      @(posedge clk); #1;
      chk("st_valid",  64'(bus.out_valid), 64'd1);
      chk("st_result", 64'(bus.result),    64'(i + 1));
      chk("st_count",  64'(bus.op_count),  64'(i % 16));
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("st_final_valid", 64'(bus.out_valid), 64'd0);
    chk("st_final_count", 64'(bus.op_count),  64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
